// File: rtl/test_result_reporter.sv
// Snapshots each new checker verdict and sends it to the host as a 5-byte UART frame (8N1, LSB first).
// Define REPORT_PARITY_EN to send 8E1 frames with an even-parity bit after each data byte.
module test_result_reporter #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned IFG_CLKS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       icg,
    input  logic [2:0] tester,
    input  logic [2:0] gate,
    input  logic [5:0] pass_vec,
    input  logic [5:0] fail_vec,
    input  logic       pass,
    input  logic       fail,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef REPORT_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(IFG_CLKS - 1);
    localparam logic [15:0] GAP_PULSE = 16'(IFG_CLKS - 2);

    state_t      state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [19:0] verdict;
    logic [19:0] shadow;
    logic [19:0] last_sent;
    logic [7:0]  b1, b2, b3;
    logic [7:0]  cur_byte;

    assign verdict = {tester, gate, pass, fail, pass_vec, fail_vec};

    // Frame bytes are always built from the shadow copy, never the live inputs.
    assign b1 = {2'b00, shadow[19:14]};
    assign b2 = {shadow[11:6], shadow[13:12]};
    assign b3 = {shadow[5:0], 2'b00};

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_cnt)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
            default: cur_byte = b1 ^ b2 ^ b3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shadow     <= '0;
            last_sent  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    clk_cnt  <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    if (!icg) begin
                        last_sent <= '0;
                    end else if ((pass | fail) && (verdict != last_sent)) begin
                        shadow    <= verdict;
                        last_sent <= verdict;
                        busy      <= 1'b1;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef REPORT_PARITY_EN
                            tx    <= ^cur_byte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= cur_byte[3'(bit_cnt + 3'd1)];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef REPORT_PARITY_EN
                PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (byte_cnt == 3'd4) begin
                            frame_done <= (IFG_CLKS == 1);
                            state      <= GAP;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (clk_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!icg) begin
                            last_sent <= '0;
                        end
                    end else begin
                        clk_cnt    <= clk_cnt + 16'd1;
                        frame_done <= (clk_cnt == GAP_PULSE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
